// File: rtl/ps2_rx_pkg.sv
// Shared types and constants for the PS/2 device-to-host frame receiver.
// Frame layout: start(0), 8 data bits LSB-first, odd parity, stop(1).
package ps2_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    localparam int   FRAME_BITS = 11;
    localparam int   DATA_BITS  = 8;
    localparam logic IDLE_LEVEL = 1'b1;

    // Odd parity holds when data plus parity bit carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 input conditioning: 2-FF synchronisers on both lines, debounce on the clock line,
// and a one-cycle strobe on each filtered clock falling edge.
module ps2_line_filter
    import ps2_rx_pkg::*;
#(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clk_pin,
    input  logic data_pin,
    output logic data_sync,
    output logic fe
);

    logic [1:0] clk_sync;
    logic [1:0] dat_sync;
    logic       clk_filt;
    logic [3:0] run_cnt;

    // The filtered level only follows the synced clock after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync <= {2{IDLE_LEVEL}};
            dat_sync <= {2{IDLE_LEVEL}};
            clk_filt <= IDLE_LEVEL;
            run_cnt  <= '0;
            fe       <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[0], clk_pin};
            dat_sync <= {dat_sync[0], data_pin};
            fe       <= 1'b0;
            if (clk_sync[1] == clk_filt) begin
                run_cnt <= '0;
            end else if (run_cnt == 4'(FILTER_LEN - 1)) begin
                clk_filt <= clk_sync[1];
                run_cnt  <= '0;
                fe       <= clk_filt;
            end else begin
                run_cnt <= run_cnt + 4'd1;
            end
        end
    end

    assign data_sync = dat_sync[1];

endmodule

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver with parity, framing and inter-edge timeout checks.
// Define PS2_RX_PACKET_EN to add 3-byte packet assembly on PKT/PKT_VALID.
module ps2_frame_receiver
    import ps2_rx_pkg::*;
#(
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ENA,
    input  logic        PS2CLK,
    input  logic        PS2DATA,
    output logic [7:0]  DOUT,
    output logic        DVALID,
    output logic        PERR,
    output logic        FERR,
    output logic        BUSY
`ifdef PS2_RX_PACKET_EN
    ,
    output logic [23:0] PKT,
    output logic        PKT_VALID
`endif
);

    logic        fe;
    logic        data_sync;
    rx_state_t   state;
    logic [7:0]  shreg;
    logic [2:0]  bit_cnt;
    logic        par;
    logic [12:0] tcnt;
`ifdef PS2_RX_PACKET_EN
    logic [1:0]  pkt_idx;
    logic [15:0] pkt_lo;
`endif

    ps2_line_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_filter (
        .clk      (CLK),
        .rst      (RST),
        .clk_pin  (PS2CLK),
        .data_pin (PS2DATA),
        .data_sync(data_sync),
        .fe       (fe)
    );

    // A falling edge always takes priority over an expiring timeout in the same cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= ST_IDLE;
            shreg   <= {8{IDLE_LEVEL}};
            bit_cnt <= '0;
            par     <= IDLE_LEVEL;
            tcnt    <= '0;
            DOUT    <= '0;
            DVALID  <= 1'b0;
            PERR    <= 1'b0;
            FERR    <= 1'b0;
            BUSY    <= 1'b0;
`ifdef PS2_RX_PACKET_EN
            pkt_idx   <= '0;
            pkt_lo    <= '0;
            PKT       <= '0;
            PKT_VALID <= 1'b0;
`endif
        end else begin
            DVALID <= 1'b0;
            PERR   <= 1'b0;
            FERR   <= 1'b0;
`ifdef PS2_RX_PACKET_EN
            PKT_VALID <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (fe && ENA && !data_sync) begin
                        state   <= ST_DATA;
                        BUSY    <= 1'b1;
                        bit_cnt <= '0;
                        tcnt    <= '0;
                    end
                end
                default: begin
                    if (fe) begin
                        tcnt <= '0;
                        case (state)
                            ST_DATA: begin
                                shreg <= {data_sync, shreg[7:1]};
                                if (bit_cnt == 3'(DATA_BITS - 1)) begin
                                    state <= ST_PARITY;
                                end else begin
                                    bit_cnt <= bit_cnt + 3'd1;
                                end
                            end
                            ST_PARITY: begin
                                par   <= data_sync;
                                state <= ST_STOP;
                            end
                            ST_STOP: begin
                                state <= ST_IDLE;
                                BUSY  <= 1'b0;
                                if (!data_sync) begin
                                    FERR <= 1'b1;
`ifdef PS2_RX_PACKET_EN
                                    pkt_idx <= '0;
`endif
                                end else if (!odd_parity_ok(shreg, par)) begin
                                    PERR <= 1'b1;
`ifdef PS2_RX_PACKET_EN
                                    pkt_idx <= '0;
`endif
                                end else begin
                                    DOUT   <= shreg;
                                    DVALID <= 1'b1;
`ifdef PS2_RX_PACKET_EN
                                    // A first byte without bit 3 set cannot start a packet; drop it to resync.
                                    if (pkt_idx == 2'd2) begin
                                        PKT       <= {shreg, pkt_lo};
                                        PKT_VALID <= 1'b1;
                                        pkt_idx   <= '0;
                                    end else if (!(pkt_idx == 2'd0 && !shreg[3])) begin
                                        pkt_lo  <= {shreg, pkt_lo[15:8]};
                                        pkt_idx <= pkt_idx + 2'd1;
                                    end
`endif
                                end
                            end
                            default: state <= ST_IDLE;
                        endcase
                    end else if (tcnt == 13'(TIMEOUT_CYC - 1)) begin
                        state <= ST_IDLE;
                        BUSY  <= 1'b0;
                        FERR  <= 1'b1;
                        tcnt  <= '0;
`ifdef PS2_RX_PACKET_EN
                        pkt_idx <= '0;
`endif
                    end else begin
                        tcnt <= tcnt + 13'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Directed self-checking bench for ps2_frame_receiver.
// Define PS2_RX_PACKET_EN to also exercise packet assembly.
module tb_ps2_frame_receiver;

    localparam int HALF = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b1;
    logic        ps2clk = 1'b1;
    logic        ps2data = 1'b1;
    logic [7:0]  dout;
    logic        dvalid;
    logic        perr;
    logic        ferr;
    logic        busy;
`ifdef PS2_RX_PACKET_EN
    logic [23:0] pkt;
    logic        pkt_valid;
`endif

    int total = 0;
    int passed = 0;
    int cyc = 0;
    int dv_cnt = 0;
    int perr_cnt = 0;
    int ferr_cnt = 0;
    int pkt_cnt = 0;
    int pkt_dv_cnt = 0;
    int ferr_cyc = 0;
    int fall_cyc = 0;
    int dv0, p0, f0, k0, kd0;

    ps2_frame_receiver #(
        .FILTER_LEN (4),
        .TIMEOUT_CYC(5000)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .ENA      (ena),
        .PS2CLK   (ps2clk),
        .PS2DATA  (ps2data),
        .DOUT     (dout),
        .DVALID   (dvalid),
        .PERR     (perr),
        .FERR     (ferr),
        .BUSY     (busy)
`ifdef PS2_RX_PACKET_EN
        ,
        .PKT      (pkt),
        .PKT_VALID(pkt_valid)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor: counts high cycles, so a stretched strobe shows up as an extra count.
    always @(negedge clk) begin
        if (dvalid) dv_cnt <= dv_cnt + 1;
        if (perr) perr_cnt <= perr_cnt + 1;
        if (ferr) begin
            ferr_cnt <= ferr_cnt + 1;
            ferr_cyc <= cyc;
        end
`ifdef PS2_RX_PACKET_EN
        if (pkt_valid) pkt_cnt <= pkt_cnt + 1;
        if (pkt_valid && dvalid) pkt_dv_cnt <= pkt_dv_cnt + 1;
`endif
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        dv0 = dv_cnt;
        p0  = perr_cnt;
        f0  = ferr_cnt;
        k0  = pkt_cnt;
        kd0 = pkt_dv_cnt;
    endtask

    function automatic logic [10:0] frame(input logic [7:0] d, input logic p, input logic s);
        return {s, p, d, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            ps2data = bits[i];
            wait_cycles(HALF / 2);
            ps2clk   = 1'b0;
            fall_cyc = cyc;
            wait_cycles(HALF);
            ps2clk = 1'b1;
            wait_cycles(HALF / 2);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        send_bits(frame(d, p, s), 0, 10);
        ps2data = 1'b1;
        wait_cycles(30);
    endtask

    task automatic glitch(input int width);
        ps2clk = 1'b0;
        wait_cycles(width);
        ps2clk = 1'b1;
        wait_cycles(20);
    endtask

    initial begin
        wait_cycles(4);
        check("rst_dout", 32'(dout), 0);
        check("rst_dvalid", 32'(dvalid), 0);
        check("rst_perr", 32'(perr), 0);
        check("rst_ferr", 32'(ferr), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        wait_cycles(10);

        // 0xFA has six ones, so odd parity is 1
        snap();
        send_frame(8'hFA, 1'b1, 1'b1);
        check("t1_dout", 32'(dout), 32'hFA);
        check("t1_dvalid_cnt", dv_cnt - dv0, 1);
        check("t1_perr_cnt", perr_cnt - p0, 0);
        check("t1_ferr_cnt", ferr_cnt - f0, 0);
        check("t1_busy", 32'(busy), 0);

        // 0x08 has one one; parity 1 makes the total even
        snap();
        send_frame(8'h08, 1'b1, 1'b1);
        check("t2_perr_cnt", perr_cnt - p0, 1);
        check("t2_dvalid_cnt", dv_cnt - dv0, 0);
        check("t2_dout_held", 32'(dout), 32'hFA);

        snap();
        send_frame(8'h00, 1'b1, 1'b0);
        check("t3_ferr_cnt", ferr_cnt - f0, 1);
        check("t3_perr_cnt", perr_cnt - p0, 0);
        check("t3_dvalid_cnt", dv_cnt - dv0, 0);
        snap();
        send_frame(8'h55, 1'b1, 1'b1);
        check("t3_dout", 32'(dout), 32'h55);
        check("t3b_dvalid_cnt", dv_cnt - dv0, 1);

        // Start plus four data bits, then the clock stalls high
        snap();
        send_bits(frame(8'h0F, 1'b1, 1'b1), 0, 4);
        check("t4_busy_mid", 32'(busy), 1);
        wait_cycles(6000);
        check("t4_ferr_cnt", ferr_cnt - f0, 1);
        check("t4_busy", 32'(busy), 0);
        check("t4_timeout_window",
              32'(((ferr_cyc - fall_cyc) >= 5000) && ((ferr_cyc - fall_cyc) <= 5015)), 1);
        check("t4_dvalid_cnt", dv_cnt - dv0, 0);
        snap();
        send_frame(8'h01, 1'b0, 1'b1);
        check("t4_dout", 32'(dout), 32'h01);
        check("t4b_dvalid_cnt", dv_cnt - dv0, 1);

        // Short clock glitches with data low in IDLE must not start a frame
        snap();
        ps2data = 1'b0;
        wait_cycles(5);
        glitch(1);
        glitch(3);
        check("t5_idle_glitch_busy", 32'(busy), 0);
        ps2data = 1'b1;
        wait_cycles(10);
        send_bits(frame(8'h3C, 1'b1, 1'b1), 0, 2);
        glitch(1);
        glitch(3);
        send_bits(frame(8'h3C, 1'b1, 1'b1), 3, 10);
        ps2data = 1'b1;
        wait_cycles(30);
        check("t5_glitch_dout", 32'(dout), 32'h3C);
        check("t5_glitch_dvalid_cnt", dv_cnt - dv0, 1);
        check("t5_glitch_err_cnt", (perr_cnt - p0) + (ferr_cnt - f0), 0);

        // Reset in the middle of a frame
        send_bits(frame(8'hC3, 1'b1, 1'b1), 0, 3);
        check("t5_busy_before_rst", 32'(busy), 1);
        rst = 1'b1;
        wait_cycles(3);
        check("t5_rst_dout", 32'(dout), 0);
        check("t5_rst_busy", 32'(busy), 0);
        rst = 1'b0;
        ps2data = 1'b1;
        wait_cycles(10);
        snap();
        send_frame(8'hA5, 1'b1, 1'b1);
        check("t5_after_rst_dout", 32'(dout), 32'hA5);
        check("t5_after_rst_dvalid_cnt", dv_cnt - dv0, 1);
        check("t5_after_rst_err_cnt", (perr_cnt - p0) + (ferr_cnt - f0), 0);

        // Receiver disabled in IDLE ignores a whole frame
        snap();
        ena = 1'b0;
        send_frame(8'h3C, 1'b1, 1'b1);
        check("ena_off_dvalid_cnt", dv_cnt - dv0, 0);
        check("ena_off_dout", 32'(dout), 32'hA5);

        // Dropping enable mid-frame lets the current frame finish
        snap();
        ena = 1'b1;
        send_bits(frame(8'h81, 1'b1, 1'b1), 0, 3);
        ena = 1'b0;
        send_bits(frame(8'h81, 1'b1, 1'b1), 4, 10);
        ps2data = 1'b1;
        wait_cycles(30);
        ena = 1'b1;
        check("ena_mid_dout", 32'(dout), 32'h81);
        check("ena_mid_dvalid_cnt", dv_cnt - dv0, 1);

`ifdef PS2_RX_PACKET_EN
        rst = 1'b1;
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(10);
        snap();
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'h08, 1'b0, 1'b1);
        send_frame(8'h01, 1'b0, 1'b1);
        check("t6_no_early_pkt", pkt_cnt - k0, 0);
        send_frame(8'hFF, 1'b1, 1'b1);
        check("t6_pkt", 32'(pkt), 32'hFF0108);
        check("t6_pkt_valid_cnt", pkt_cnt - k0, 1);
        check("t6_pkt_with_dvalid", pkt_dv_cnt - kd0, 1);
        check("t6_dvalid_cnt", dv_cnt - dv0, 4);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
